sprite_game_ctrl: RTL and testbench
===================================

# sprite_game_ctrl

Frame-rate controller that sequences the player sprite layer of the graphics pipeline. It debounces the three push buttons against the vertical sync and moves the player sprite with saturating arithmetic. It detects per-pixel overlap between the two sprite layers and runs the game state machine (idle, play, hit-blink, game over). Its outputs drive the position and visibility inputs of the player sprite compositor, so the pixel path stays purely combinational.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 32, player sprite width
- SPRITE_H, 32, player sprite height
- STEP, 4, pixels moved per frame
- LIVES, 3, starting lives (1..3)
- HIT_FRAMES, 60, blink duration after a hit (1..255)

Ports:
- i_clk  in  1  pixel clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_btn1  in  1  left button, asynchronous
- i_btn2  in  1  right button, asynchronous
- i_btn3  in  1  start/restart button, asynchronous
- i_v_sync  in  1  vertical sync, active high
- i_sprite_hit  in  1  enemy sprite pixel hit, synchronous to i_clk
- i_sprite2_hit  in  1  player sprite pixel hit, synchronous to i_clk
- o_sprite2_x  out  16  player sprite left edge
- o_sprite2_y  out  16  player sprite top edge, constant SCREEN_H-SPRITE_H-16
- o_sprite2_visible  out  1  player sprite enable
- o_state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3
- o_lives  out  2  remaining lives
- o_collision  out  1  one-cycle pulse when a life is lost
- o_frame_tick  out  1  one-cycle pulse per frame

## Operation
- Synchronisation:
  - i_btn1..3 and i_v_sync each pass through a 2-FF synchroniser.
  - o_frame_tick = rising edge of the synchronised v_sync.
- Debounce:
  - Each button is sampled on every frame tick into a 2-bit history.
  - A button counts as pressed when both history bits are 1.
  - btn3_edge = pressed now AND not pressed at the previous tick.
- Centre position: X0 = (SCREEN_W-SPRITE_W)/2.
- IDLE:
  - x = X0, lives = LIVES, visible = 1.
  - btn3_edge → PLAY.
- PLAY, evaluated on each tick:
  - If collide_flag is set: lives -= 1 and o_collision pulses.
    - lives reaches 0 → OVER.
    - Otherwise → HIT, timer = HIT_FRAMES.
    - Position does not change on that tick.
  - Else btn1 only: x = max(x-STEP, 0).
  - Else btn2 only: x = min(x+STEP, SCREEN_W-SPRITE_W).
  - Both or neither pressed: x holds.
- HIT, evaluated on each tick:
  - Movement rules as in PLAY; collisions are ignored.
  - timer -= 1; visible = timer[2].
  - timer reaches 0 → PLAY, visible = 1.
- OVER:
  - Position is frozen, visible = 1.
  - btn3_edge → IDLE, which reloads x and lives.
- collide_flag:
  - Sticky. Set in any cycle where i_sprite_hit && i_sprite2_hit while state = PLAY.
  - Cleared on every tick. In the same cycle, a set wins over the clear and counts toward the next frame.
  - Held at 0 outside PLAY.
- Arithmetic:
  - x is 16-bit unsigned.
  - Saturation is computed before wrap: the subtract is checked as x < STEP → 0, so there is no underflow.
- State transitions occur only on ticks. Buttons between ticks are ignored.

## Timing
- Reset values (asynchronous):
  - o_state = IDLE, o_lives = LIVES, o_sprite2_x = X0, o_sprite2_y = constant.
  - o_sprite2_visible = 1, o_collision = 0, o_frame_tick = 0.
  - Timer, collide_flag, debounce histories and synchronisers = 0.
- Tick latency: an i_v_sync rising edge produces o_frame_tick 3 cycles later (2 sync + 1 edge register).
- Update latency: all state, position, lives and visibility outputs update in the cycle after o_frame_tick and are registered.
- o_collision is high in that same update cycle, for exactly one cycle.
- Hit sampling: a coincident hit in cycle N sets collide_flag from cycle N+1.
- Button latency: a button held from before tick T is first "pressed" at the update of tick T+1, because 2 samples are required.
- Reset mid-frame: everything returns to reset values immediately; no tick is generated until the next v_sync rising edge after release.

## Test plan
- Reset, release, 3 v_sync pulses with btn3 held from frame 0 → PLAY after the second tick, x = 304, lives = 3, visible = 1.
- PLAY, btn1 held 100 frames from x = 304 → x decreases by 4 per tick and saturates at 0. Then btn2 held → x saturates at 608. Both held → x unchanged.
- PLAY, both hit inputs high for one cycle mid-frame → at the next tick o_collision pulses once, lives = 2, state = HIT, x unchanged. visible toggles every 4 ticks and returns to PLAY after 60 ticks.
- HIT, coincident hits every frame → lives stay 2 and no o_collision.
- Three collisions in separate PLAY windows → lives 0, state = OVER. btn3 press edge → IDLE with lives = 3, x = 304.
- Coincident hit in the same cycle as o_frame_tick → no life lost at that tick; one life lost at the following tick. Assert i_rst_n low mid-HIT → outputs at reset values within the same cycle.

Source files
------------

// File: rtl/sprite_game_ctrl.sv
// sprite_game_ctrl: frame-rate player sprite controller with debounce, saturating motion and game FSM
module sprite_game_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int STEP       = 4,
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_btn1,
  input  logic        i_btn2,
  input  logic        i_btn3,
  input  logic        i_v_sync,
  input  logic        i_sprite_hit,
  input  logic        i_sprite2_hit,
  output logic [15:0] o_sprite2_x,
  output logic [15:0] o_sprite2_y,
  output logic        o_sprite2_visible,
  output logic [1:0]  o_state,
  output logic [1:0]  o_lives,
  output logic        o_collision,
  output logic        o_frame_tick
);
  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_e;
  localparam logic [15:0] X0     = 16'((SCREEN_W - SPRITE_W) / 2);
  localparam logic [15:0] XMAX   = 16'(SCREEN_W - SPRITE_W);
  localparam logic [15:0] Y0     = 16'(SCREEN_H - SPRITE_H - 16);
  localparam logic [15:0] STEP_W = 16'(STEP);
  localparam logic [1:0]  LIVES_W = 2'(LIVES);
  localparam logic [7:0]  HIT_W  = 8'(HIT_FRAMES);
  logic [2:0]  btn_m_q, btn_s_q, samp_q;
  logic        vs_m_q, vs_s_q, vs_d_q, tick_q;
  logic        prs3_q;
  logic [2:0]  pressed;
  logic        btn3_edge, left, right;
  state_e      state_q, state_d;
  logic [15:0] x_q, x_d, x_mv;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  timer_q, timer_d, timer_dec;
  logic        vis_q, vis_d, coll_q, coll_d, collide_q, collide_d;
  // two-flop synchronisers for buttons and v_sync, plus registered rising-edge tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_m_q <= '0;
      btn_s_q <= '0;
      vs_m_q  <= 1'b0;
      vs_s_q  <= 1'b0;
      vs_d_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      btn_m_q <= {i_btn3, i_btn2, i_btn1};
      btn_s_q <= btn_m_q;
      vs_m_q  <= i_v_sync;
      vs_s_q  <= vs_m_q;
      vs_d_q  <= vs_s_q;
      tick_q  <= vs_s_q & ~vs_d_q;
    end
  end
  // a button is pressed when this tick's sample and the previous tick's sample are both high
  always_comb begin
    pressed   = samp_q & btn_s_q;
    btn3_edge = pressed[2] & ~prs3_q;
    left      = pressed[0] & ~pressed[1];
    right     = pressed[1] & ~pressed[0];
    x_mv      = left  ? (x_q < STEP_W ? 16'd0 : x_q - STEP_W) :
                right ? (x_q > XMAX - STEP_W ? XMAX : x_q + STEP_W) : x_q;
    timer_dec = timer_q - 8'd1;
    collide_d = (state_q == PLAY) & ((i_sprite_hit & i_sprite2_hit) | (collide_q & ~tick_q));
  end
  // game state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  // datapath registers: debounce history, position, lives, blink timer, collision flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_q    <= '0;
      prs3_q    <= 1'b0;
      x_q       <= X0;
      lives_q   <= LIVES_W;
      timer_q   <= '0;
      vis_q     <= 1'b1;
      coll_q    <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      if (tick_q) begin
        samp_q <= btn_s_q;
        prs3_q <= pressed[2];
      end
      x_q       <= x_d;
      lives_q   <= lives_d;
      timer_q   <= timer_d;
      vis_q     <= vis_d;
      coll_q    <= coll_d;
      collide_q <= collide_d;
    end
  end
  // next state and datapath, evaluated only on frame ticks
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    lives_d = lives_q;
    timer_d = timer_q;
    vis_d   = vis_q;
    coll_d  = 1'b0;
    if (tick_q) begin
      case (state_q)
        IDLE: begin
          x_d     = X0;
          lives_d = LIVES_W;
          vis_d   = 1'b1;
          state_d = btn3_edge ? PLAY : IDLE;
        end
        PLAY: begin
          if (collide_q) begin
            lives_d = lives_q - 2'd1;
            coll_d  = 1'b1;
            timer_d = HIT_W;
            state_d = (lives_q == 2'd1) ? OVER : HIT;
          end else x_d = x_mv;
        end
        HIT: begin
          x_d     = x_mv;
          timer_d = timer_dec;
          vis_d   = (timer_dec == 8'd0) | timer_dec[2];
          state_d = (timer_dec == 8'd0) ? PLAY : HIT;
        end
        OVER: begin
          vis_d = 1'b1;
          if (btn3_edge) begin
            state_d = IDLE;
            x_d     = X0;
            lives_d = LIVES_W;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs come straight from registers so the compositor sees glitch-free values
  always_comb begin
    o_state           = state_q;
    o_lives           = lives_q;
    o_sprite2_x       = x_q;
    o_sprite2_y       = Y0;
    o_sprite2_visible = vis_q;
    o_collision       = coll_q;
    o_frame_tick      = tick_q;
  end
endmodule

// File: tb/tb_sprite_game_ctrl.sv
// tb_sprite_game_ctrl: scoreboard bench driving directed frames and checking each tick update
module tb_sprite_game_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, vs = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic [15:0] o_x, o_y;
  logic        o_vis, o_col, o_tick;
  logic [1:0]  o_state, o_lives;
  typedef struct {int st; int lv; int x; int vis; int col;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit upd = 1'b0;
  sprite_game_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn1(b1), .i_btn2(b2), .i_btn3(b3),
    .i_v_sync(vs), .i_sprite_hit(h1), .i_sprite2_hit(h2),
    .o_sprite2_x(o_x), .o_sprite2_y(o_y), .o_sprite2_visible(o_vis),
    .o_state(o_state), .o_lives(o_lives), .o_collision(o_col), .o_frame_tick(o_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // monitor: the cycle after each frame tick carries the update to be scored
  always @(negedge clk) begin
    if (!rst_n) upd = 1'b0;
    else begin
      if (upd) begin
        if (q.size() == 0) chk("unexpected_update", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("state", int'(o_state), e.st);
          chk("lives", int'(o_lives), e.lv);
          chk("x", int'(o_x), e.x);
          chk("visible", int'(o_vis), e.vis);
          chk("collision", int'(o_col), e.col);
          chk("y", int'(o_y), 432);
        end
      end else chk("collision_idle", int'(o_col), 0);
      upd = o_tick;
    end
  end
  task automatic frame(input int f1, input int f2, input int f3, input int h,
                       input int es, input int el, input int ex, input int ev, input int ec);
    exp_t e;
    int n;
    b1 = (f1 != 0); b2 = (f2 != 0); b3 = (f3 != 0);
    e.st = es; e.lv = el; e.x = ex; e.vis = ev; e.col = ec;
    q.push_back(e);
    repeat (2) @(negedge clk);
    if (h == 1) begin
      h1 = 1'b1; h2 = 1'b1;
      @(negedge clk);
      h1 = 1'b0; h2 = 1'b0;
    end
    repeat (2) @(negedge clk);
    vs = 1'b1;
    n = 0;
    while (!o_tick && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!o_tick) begin
      bad++;
      $display("FAIL tick_timeout: no o_frame_tick within 10 cycles, required 3");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
    end
    chk("tick_latency", n, 3);
    if (h == 2) begin
      h1 = 1'b1; h2 = 1'b1;
    end
    @(negedge clk);
    h1 = 1'b0; h2 = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic chk_reset();
    chk("rst_state", int'(o_state), 0);
    chk("rst_lives", int'(o_lives), 3);
    chk("rst_x", int'(o_x), 304);
    chk("rst_y", int'(o_y), 432);
    chk("rst_visible", int'(o_vis), 1);
    chk("rst_collision", int'(o_col), 0);
    chk("rst_tick", int'(o_tick), 0);
  endtask
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int ex, t;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    frame(0, 0, 1, 0, 0, 3, 304, 1, 0);
    frame(0, 0, 1, 0, 1, 3, 304, 1, 0);
    frame(0, 0, 1, 0, 1, 3, 304, 1, 0);
    for (int k = 1; k <= 100; k++) begin
      ex = 304 - 4 * (k - 1);
      frame(1, 0, 0, 0, 1, 3, ex < 0 ? 0 : ex, 1, 0);
    end
    for (int k = 1; k <= 160; k++) begin
      ex = 4 * (k - 1);
      frame(0, 1, 0, 0, 1, 3, ex > 608 ? 608 : ex, 1, 0);
    end
    repeat (3) frame(1, 1, 0, 0, 1, 3, 608, 1, 0);
    frame(0, 0, 0, 0, 1, 3, 608, 1, 0);
    frame(0, 0, 0, 1, 2, 2, 608, 1, 1);
    for (int j = 1; j <= 60; j++) begin
      t = 60 - j;
      frame(0, 0, 0, 1, t == 0 ? 1 : 2, 2, 608, t == 0 ? 1 : (t >> 2) & 1, 0);
    end
    frame(0, 0, 0, 1, 2, 1, 608, 1, 1);
    for (int j = 1; j <= 60; j++) begin
      t = 60 - j;
      frame(0, 0, 0, 0, t == 0 ? 1 : 2, 1, 608, t == 0 ? 1 : (t >> 2) & 1, 0);
    end
    frame(0, 0, 0, 1, 3, 0, 608, 1, 1);
    frame(1, 0, 0, 0, 3, 0, 608, 1, 0);
    frame(1, 0, 0, 0, 3, 0, 608, 1, 0);
    frame(0, 0, 1, 0, 3, 0, 608, 1, 0);
    frame(0, 0, 1, 0, 0, 3, 304, 1, 0);
    frame(0, 0, 0, 0, 0, 3, 304, 1, 0);
    frame(0, 0, 0, 0, 0, 3, 304, 1, 0);
    frame(0, 0, 1, 0, 0, 3, 304, 1, 0);
    frame(0, 0, 1, 0, 1, 3, 304, 1, 0);
    frame(0, 0, 0, 2, 1, 3, 304, 1, 0);
    frame(0, 0, 0, 0, 2, 2, 304, 1, 1);
    frame(0, 0, 0, 0, 2, 2, 304, 0, 0);
    chk("queue_before_reset", q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(0, 0, 0, 0, 0, 3, 304, 1, 0);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
